conv_window_feeder: RTL and testbench
=====================================

Name: conv_window_feeder

Overview:
- Upstream stage of the 6-bit bit-serial convolutor.
- Accepts a serial sample stream with a valid/ready handshake and holds a programmable kernel.
- Presents a sliding 6-bit sample window (A) and the kernel (B) to the convolutor, plus a one-cycle start pulse.
- Holds A/B stable for the convolutor's full computation time, and stalls the stream (in_ready low) during that time.

Parameters:
WIDTH, 6, window/kernel width in bits; must match the convolutor operand width
CONV_LATENCY, 7, cycles A/B are held stable per issued window, start cycle included (convolutor Start + 5 shifts + End)
INIT_KERNEL, 6'b000000, kernel value after reset

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (sampled on rising edge of clock; 0 = reset)
in_bit  input  1  serial sample bit
in_valid  input  1  in_bit is valid this cycle
in_ready  output  1  block accepts in_bit this cycle; transfer occurs when in_valid && in_ready
kern_load  input  1  capture kern_in into the pending-kernel register this cycle
kern_in  input  WIDTH  new kernel value
A  output  WIDTH  current sample window to convolutor, LSB = oldest sample
B  output  WIDTH  kernel to convolutor
start  output  1  one-cycle pulse: new A/B valid, convolutor begins
win_count  output  8  number of windows issued, wraps 255 -> 0

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=FILL, window=0, fill_cnt=0, hold_cnt=0, A=0.
  - B=INIT_KERNEL, pending kernel=INIT_KERNEL.
  - start=0, in_ready=1, win_count=0.
  - Reset mid-HOLD abandons the window; no start is issued for it.
- Window shift on each accepted bit: window <= {in_bit, window[WIDTH-1:1]}. The newest bit enters the MSB and the oldest sits at the LSB, matching the convolutor's LSB-first consumption.
- Pending kernel:
  - kern_load captures kern_in in any state.
  - B takes the pending value only at an issue edge, so B never changes during HOLD.
  - If kern_load coincides with an issue edge, kern_in is bypassed directly into B.
- State FILL (in_ready=1): each accept increments fill_cnt, which saturates at WIDTH. The accept that brings fill_cnt to WIDTH is an issue edge.
- Issue edge (same clock edge as the accept):
  - A <= shifted window; B <= pending/bypassed kernel.
  - state <= ISSUE; win_count += 1.
- State ISSUE (1 cycle): start=1, in_ready=0, hold_cnt <= 1; next state is HOLD.
- State HOLD: start=0, in_ready=0, hold_cnt increments each cycle. When hold_cnt==CONV_LATENCY-1, next state is READY.
  - Result: A/B are stable for exactly CONV_LATENCY cycles, counted from the start cycle.
- State READY (in_ready=1, window full): every accept is an issue edge, so windows slide by one sample per issue.
- in_valid low in FILL/READY: the block waits indefinitely and its state is unchanged.
- in_valid asserted while in_ready=0: the bit is not consumed; the source holds it.
- Start-to-start spacing is at least CONV_LATENCY+1 cycles at a sustained in_valid=1: the issue cycle, CONV_LATENCY-1 hold cycles, and one READY cycle to accept.
- start is never asserted in two consecutive cycles.

Optional Feature:
- Macro: CONV_ZERO_PAD_EN.
- Defined: reset enters READY instead of FILL with window=0, so the first accepted bit issues A = {bit, 5'b0}. This gives leading zero-padding, and output count equals input count.
- Undefined: the first issue happens at the WIDTH-th accepted bit, i.e. a valid-only convolution.

Decomposition:
- Package conv_pkg holds:
  - WIDTH and CONV_LATENCY defaults;
  - the state enum {FILL, ISSUE, HOLD, READY};
  - the hold counter width as a localparam ($clog2(CONV_LATENCY)+1).
- One natural sub-module: conv_window_shifter. It contains the window register with synchronous active-low clear, shift-enable and serial-in, and outputs the next-window value used for the A bypass at the issue edge.
- FSM, counters and the kernel registers stay in the top module.

Test Plan:
1. Reset, then kern_load=1 with kern_in=6'b111111, then stream 1,0,1,1,0,0 with in_valid=1 every cycle -> the cycle after the 6th accept has start=1, A=6'b001101, B=6'b111111, win_count=1; in_ready=0 for 7 cycles; A/B unchanged throughout.
2. Continue from test 1 with bit 1 -> second start, A=6'b100110, win_count=2; start-to-start spacing = 8 cycles.
3. kern_load=1 with kern_in=6'b000011 during HOLD -> B stays 6'b111111 until the next issue, then becomes 6'b000011. kern_load on the issue edge itself -> the new kern_in appears on B at that start.
4. Drive reset=0 during HOLD (hold_cnt=3) -> next cycle start=0, A=0, B=INIT_KERNEL, win_count=0, in_ready=1; the next start occurs only after 6 fresh bits.
5. Toggle in_valid randomly during FILL/READY and keep it at 1 during HOLD -> only bits accepted when in_ready=1 enter the window; the sequence of A matches a software sliding-window model.
6. Build with CONV_ZERO_PAD_EN defined, reset, send bit 1 -> start the next cycle with A=6'b100000. Build without the macro and send 256 windows -> win_count wraps to 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolutor window feeder.
package conv_pkg;

    localparam int DEF_WIDTH        = 6;
    localparam int DEF_CONV_LATENCY = 7;
    localparam int HOLD_W           = $clog2(DEF_CONV_LATENCY) + 1;

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        HOLD,
        READY
    } conv_state_e;

endpackage

// File: rtl/conv_window_shifter.sv
// Serial-in sliding window register; newest bit enters the MSB, oldest sits at the LSB.
module conv_window_shifter #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] win_o,
    output logic [WIDTH-1:0] win_next_o
);

    logic [WIDTH-1:0] win_q;
    logic [WIDTH-1:0] win_d;

    assign win_next_o = {bit_i, win_q[WIDTH-1:1]};
    assign win_d      = shift_en_i ? win_next_o : win_q;
    assign win_o      = win_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Feeds sample windows (A) and kernel (B) to the bit-serial convolutor and stalls the stream while it runs.
// CONV_ZERO_PAD_EN: reset straight into READY so the first bit issues a zero-padded window.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               CONV_LATENCY = DEF_CONV_LATENCY,
    parameter logic [WIDTH-1:0] INIT_KERNEL  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             kern_load,
    input  logic [WIDTH-1:0] kern_in,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             start,
    output logic [7:0]       win_count,
    output conv_state_e      dbg_state
);

    localparam int FILL_W = $clog2(WIDTH + 1);

`ifdef CONV_ZERO_PAD_EN
    localparam conv_state_e RESET_STATE = READY;
`else
    localparam conv_state_e RESET_STATE = FILL;
`endif

    conv_state_e       state_q, state_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic [7:0]        win_count_q, win_count_d;
    logic              issue;
    logic              shift_en;
    logic [WIDTH-1:0]  win_cur;
    logic [WIDTH-1:0]  win_next;

    assign shift_en = in_valid && in_ready;

    conv_window_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .shift_en_i (shift_en),
        .bit_i      (in_bit),
        .win_o      (win_cur),
        .win_next_o (win_next)
    );

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        pend_d      = pend_q;
        win_count_d = win_count_q;
        in_ready    = 1'b0;
        start       = 1'b0;
        issue       = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (fill_cnt_q != FILL_W'(WIDTH)) fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == FILL_W'(WIDTH - 1)) issue = 1'b1;
                end
            end
            ISSUE: begin
                start      = 1'b1;
                hold_cnt_d = HOLD_W'(1);
                state_d    = HOLD;
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_W'(CONV_LATENCY - 1)) state_d = READY;
            end
            READY: begin
                in_ready = 1'b1;
                if (in_valid) issue = 1'b1;
            end
            default: state_d = RESET_STATE;
        endcase

        if (kern_load) pend_d = kern_in;

        // A kernel loaded on the issue edge itself goes straight to B.
        if (issue) begin
            a_d         = win_next;
            b_d         = kern_load ? kern_in : pend_q;
            state_d     = ISSUE;
            win_count_d = win_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            fill_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            a_q         <= '0;
            b_q         <= INIT_KERNEL;
            pend_q      <= INIT_KERNEL;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pend_q      <= pend_d;
            win_count_q <= win_count_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign win_count = win_count_q;
    assign dbg_state = state_q;

    logic unused_win;
    assign unused_win = ^win_cur;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench: directed scenarios plus random streams against a sliding-window reference model.
module tb_conv_window_feeder;
    import conv_pkg::*;

    localparam int         W      = 6;
    localparam int         LAT    = 7;
    localparam logic [5:0] INIT_K = 6'b000000;
`ifdef CONV_ZERO_PAD_EN
    localparam int FIRST_ISSUE = 1;
`else
    localparam int FIRST_ISSUE = W;
`endif

    logic        clock;
    logic        reset;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic        kern_load;
    logic [5:0]  kern_in;
    logic [5:0]  A;
    logic [5:0]  B;
    logic        start;
    logic [7:0]  win_count;
    conv_state_e dbg_state;

    conv_window_feeder #(
        .WIDTH        (W),
        .CONV_LATENCY (LAT),
        .INIT_KERNEL  (INIT_K)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kern_load (kern_load),
        .kern_in   (kern_in),
        .A         (A),
        .B         (B),
        .start     (start),
        .win_count (win_count),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard state
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_start = -1;
    logic       hist[$];
    int         n_acc = 0;
    int         busy = 0;
    logic [5:0] m_a = '0;
    logic [5:0] m_b = INIT_K;
    logic [5:0] m_pend = INIT_K;
    logic [7:0] m_win = '0;
    logic [7:0] prev_win = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [5:0] model_window();
        logic [5:0] r;
        r = '0;
        for (int k = 0; k < W; k++)
            if (hist.size() > k) r[W-1-k] = hist[hist.size()-1-k];
        return r;
    endfunction

    task automatic model_edge();
        logic ready;
        if (!reset) begin
            hist.delete();
            n_acc  = 0;
            busy   = 0;
            m_a    = '0;
            m_b    = INIT_K;
            m_pend = INIT_K;
            m_win  = '0;
            return;
        end
        ready = (busy == 0);
        if (busy > 0) busy--;
        if (in_valid && ready) begin
            hist.push_back(in_bit);
            if (hist.size() > W) void'(hist.pop_front());
            n_acc++;
            if (n_acc >= FIRST_ISSUE) begin
                m_a   = model_window();
                m_b   = kern_load ? kern_in : m_pend;
                m_win = m_win + 8'd1;
                busy  = LAT;
            end
        end
        if (kern_load) m_pend = kern_in;
    endtask

    task automatic compare_all();
        chk("in_ready", in_ready, busy == 0);
        chk("start", start, busy == LAT);
        chk("A", A, m_a);
        chk("B", B, m_b);
        chk("win_count", win_count, m_win);
        if (start) begin
            if (last_start >= 0) chk("start_gap_min", (cyc - last_start) >= LAT + 1, 1);
            last_start = cyc;
        end
        if (prev_win == 8'd255 && m_win == 8'd0) chk("win_wrap", win_count, 0);
        prev_win = m_win;
    endtask

    // driver: one clock cycle with the given inputs, then model update and check
    task automatic cycle(input logic v, input logic b, input logic kl, input logic [5:0] kin,
                         input logic rst_n);
        in_valid  = v;
        in_bit    = b;
        kern_load = kl;
        kern_in   = kin;
        reset     = rst_n;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc++;
        if (!rst_n) last_start = -1;
        compare_all();
    endtask

    initial begin
        int low;
        int first_start;
        logic bits1 [6];
        bits1 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        in_valid = 0; in_bit = 0; kern_load = 0; kern_in = '0; reset = 0;

        cycle(0, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 0);
        chk("rst_A", A, 0);
        chk("rst_B", B, INIT_K);
        chk("rst_start", start, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_win", win_count, 0);

`ifndef CONV_ZERO_PAD_EN
        chk("rst_state", dbg_state, FILL);
        // kernel load, then the 1,0,1,1,0,0 stream
        cycle(0, 0, 1, 6'h3f, 1);
        for (int i = 0; i < 6; i++) cycle(1, bits1[i], 0, '0, 1);
        chk("t1_start", start, 1);
        chk("t1_A", A, 6'b001101);
        chk("t1_B", B, 6'h3f);
        chk("t1_win", win_count, 1);
        first_start = cyc;
        low = in_ready ? 0 : 1;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, i == 2, 6'b000011, 1);
            if (!in_ready) low++;
            chk("t1_A_hold", A, 6'b001101);
            chk("t3_B_hold", B, 6'h3f);
        end
        chk("t1_ready_low", low, 7);
        cycle(1, 1, 0, '0, 1);
        chk("t2_ready", in_ready, 1);
        cycle(1, 1, 0, '0, 1);
        chk("t2_start", start, 1);
        chk("t2_A", A, 6'b100110);
        chk("t3_B_new", B, 6'b000011);
        chk("t2_win", win_count, 2);
        chk("t2_gap", cyc - first_start, 8);

        // kernel loaded on the issue edge is bypassed into B
        for (int i = 0; i < 20 && !in_ready; i++) cycle(1, 1'($urandom_range(0, 1)), 0, '0, 1);
        cycle(1, 0, 1, 6'b101010, 1);
        chk("t3_bypass_start", start, 1);
        chk("t3_bypass_B", B, 6'b101010);

        // reset with hold_cnt == 3
        cycle(1, 1, 0, '0, 1);
        cycle(1, 1, 0, '0, 1);
        cycle(1, 1, 0, '0, 1);
        cycle(1, 1, 0, '0, 0);
        chk("t4_start", start, 0);
        chk("t4_A", A, 0);
        chk("t4_B", B, INIT_K);
        chk("t4_win", win_count, 0);
        chk("t4_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1'($urandom_range(0, 1)), 0, '0, 1);
            chk("t4_no_start", start, 0);
        end
        cycle(1, 1, 0, '0, 1);
        chk("t4_start6", start, 1);
`else
        chk("rst_state", dbg_state, READY);
        cycle(1, 1, 0, '0, 1);
        chk("zp_start", start, 1);
        chk("zp_A", A, 6'b100000);
        chk("zp_win", win_count, 1);
`endif

        // random valid/kernel traffic with rare resets
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, 6'($urandom_range(0, 63)),
                  $urandom_range(0, 199) != 0);

        // sustained stream long enough for win_count to wrap
        for (int i = 0; i < 2200; i++)
            cycle(1, 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
                  6'($urandom_range(0, 63)), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
